// File: rtl/av_menu_pkg.sv
// av_menu_pkg: state encoding and pause-menu item constants for the menu controller
package av_menu_pkg;
  typedef enum logic [1:0] {MENU = 2'd0, COUNTDOWN = 2'd1, PLAYING = 2'd2, PAUSED = 2'd3} state_t;
  localparam int RESUME = 0;
  localparam int RESTART = 1;
  localparam int QUIT = 2;
  localparam int PAUSE_ITEMS = 3;
endpackage

// File: rtl/av_menu_controller_if.sv
// av_menu_controller_if: front-panel/game-core signals of the menu controller
interface av_menu_controller_if #(parameter int SEL_W = 2, parameter int CNT_W = 8);
  logic btn_up, btn_down, btn_enter, btn_pause, frame_tick, song_done;
  logic pause, overlay_en, game_reset, game_start;
  logic [SEL_W-1:0] menu_sel, song_sel;
  logic [CNT_W-1:0] countdown;
  logic [1:0] state;
  modport master(output btn_up, btn_down, btn_enter, btn_pause, frame_tick, song_done,
                 input pause, overlay_en, game_reset, game_start, menu_sel, song_sel, countdown, state);
  modport slave(input btn_up, btn_down, btn_enter, btn_pause, frame_tick, song_done,
                output pause, overlay_en, game_reset, game_start, menu_sel, song_sel, countdown, state);
endinterface

// File: rtl/av_btn_edge.sv
// av_btn_edge: rising-edge detector, one event per press of a held level
module av_btn_edge #(parameter int W = 4) (
  input  logic         clk65,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] ev
);
  logic [W-1:0] prev;
  always_ff @(posedge clk65)
    if (reset) prev <= '0;
    else prev <= d;
  assign ev = d & ~prev;
endmodule

// File: rtl/av_menu_controller.sv
// av_menu_controller: menu/countdown/play/pause sequencer driving overlay and game-core pulses
module av_menu_controller
  import av_menu_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int SEL_W = 2,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int CNT_W = 8
) (
  input logic clk65,
  input logic reset,
  av_menu_controller_if.slave bus
);
  localparam logic [CNT_W-1:0] FRAMES = CNT_W'(COUNTDOWN_FRAMES);
  localparam logic [SEL_W-1:0] LAST_SONG = SEL_W'(NUM_SONGS - 1);
  localparam logic [SEL_W-1:0] LAST_PAUSE = SEL_W'(PAUSE_ITEMS - 1);
  logic [3:0] ev;
  logic p, e, u, dn;
  state_t state_q, state_n;
  logic [SEL_W-1:0] sel_q, sel_n, song_q, song_n, last;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic grst_q, grst_n, gstart_q, gstart_n, pause_q, overlay_q;
  av_btn_edge #(.W(4)) u_edge (
    .clk65(clk65),
    .reset(reset),
    .d({bus.btn_pause, bus.btn_enter, bus.btn_up, bus.btn_down}),
    .ev(ev)
  );
  // only the highest-priority event of a cycle survives, even if the state ignores it
  assign p = ev[3];
  assign e = ev[2] & ~ev[3];
  assign u = ev[1] & ~|ev[3:2];
  assign dn = ev[0] & ~|ev[3:1];
  always_comb begin
    state_n = state_q;
    sel_n = sel_q;
    song_n = song_q;
    cnt_n = cnt_q;
    grst_n = 1'b0;
    gstart_n = 1'b0;
    last = state_q == PAUSED ? LAST_PAUSE : LAST_SONG;
    case (state_q)
      MENU: if (e) begin
        song_n = sel_q;
        grst_n = 1'b1;
        cnt_n = FRAMES;
        state_n = COUNTDOWN;
      end
      COUNTDOWN: if (p) begin
        cnt_n = '0;
        state_n = PAUSED;
      end else if (bus.frame_tick && cnt_q != '0) begin
        cnt_n = cnt_q - 1'b1;
        gstart_n = cnt_q == CNT_W'(1);
        state_n = cnt_q == CNT_W'(1) ? PLAYING : COUNTDOWN;
      end
      PLAYING: state_n = bus.song_done ? MENU : p ? PAUSED : PLAYING;
      PAUSED: if (p || (e && sel_q == SEL_W'(RESUME))) begin
        cnt_n = FRAMES;
        state_n = COUNTDOWN;
      end else if (e) begin
        grst_n = 1'b1;
        cnt_n = sel_q == SEL_W'(RESTART) ? FRAMES : '0;
        state_n = sel_q == SEL_W'(RESTART) ? COUNTDOWN : MENU;
      end
      default: state_n = MENU;
    endcase
    if (state_q == MENU || state_q == PAUSED)
      sel_n = u ? (sel_q == '0 ? last : sel_q - 1'b1) : dn ? (sel_q == last ? '0 : sel_q + 1'b1) : sel_q;
    if (state_n != state_q && (state_n == MENU || state_n == PAUSED)) sel_n = '0;
  end
  always_ff @(posedge clk65)
    if (reset) begin
      state_q <= MENU;
      sel_q <= '0;
      song_q <= '0;
      cnt_q <= '0;
      grst_q <= 1'b0;
      gstart_q <= 1'b0;
      pause_q <= 1'b1;
      overlay_q <= 1'b1;
    end else begin
      state_q <= state_n;
      sel_q <= sel_n;
      song_q <= song_n;
      cnt_q <= cnt_n;
      grst_q <= grst_n;
      gstart_q <= gstart_n;
      pause_q <= state_n != PLAYING;
      overlay_q <= state_n == MENU || state_n == PAUSED;
    end
  assign bus.state = state_q;
  assign bus.menu_sel = sel_q;
  assign bus.song_sel = song_q;
  assign bus.countdown = cnt_q;
  assign bus.game_reset = grst_q;
  assign bus.game_start = gstart_q;
  assign bus.pause = pause_q;
  assign bus.overlay_en = overlay_q;
endmodule

// File: tb/tb_av_menu_controller.sv
// tb_av_menu_controller: directed test-plan sequences plus random stimulus against a behavioural model
module tb_av_menu_controller;
  localparam int NS = 4;
  localparam int CF = 180;
  logic clk65 = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int m_state, m_sel, m_song, m_cnt, m_grst, m_gstart;
  logic [3:0] m_prev;
  logic [3:0] rb;
  av_menu_controller_if #(.SEL_W(2), .CNT_W(8)) bus ();
  av_menu_controller #(.NUM_SONGS(NS), .SEL_W(2), .COUNTDOWN_FRAMES(CF), .CNT_W(8)) dut (
    .clk65(clk65),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk65 = ~clk65;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // behavioural reference: buttons b = {pause, enter, up, down}
  task automatic model(input logic [3:0] b, input logic ft, input logic sd, input logic rs);
    logic [3:0] ev;
    int act, n;
    if (rs) begin
      m_state = 0; m_sel = 0; m_song = 0; m_cnt = 0; m_grst = 0; m_gstart = 0; m_prev = '0;
      return;
    end
    ev = b & ~m_prev;
    m_prev = b;
    act = -1;
    for (int i = 0; i < 4; i++) if (ev[i]) act = i;
    m_grst = 0;
    m_gstart = 0;
    n = m_state == 3 ? 3 : NS;
    if (m_state == 0) begin
      if (act == 2) begin m_song = m_sel; m_grst = 1; m_cnt = CF; m_state = 1; end
      else if (act == 1) m_sel = (m_sel + n - 1) % n;
      else if (act == 0) m_sel = (m_sel + 1) % n;
    end else if (m_state == 1) begin
      if (act == 3) begin m_state = 3; m_cnt = 0; m_sel = 0; end
      else if (ft) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_gstart = 1; m_state = 2; end
      end
    end else if (m_state == 2) begin
      if (sd) begin m_state = 0; m_sel = 0; end
      else if (act == 3) begin m_state = 3; m_sel = 0; end
    end else begin
      if (act == 3 || (act == 2 && m_sel == 0)) begin m_cnt = CF; m_state = 1; end
      else if (act == 2 && m_sel == 1) begin m_grst = 1; m_cnt = CF; m_state = 1; end
      else if (act == 2) begin m_grst = 1; m_state = 0; m_sel = 0; end
      else if (act == 1) m_sel = (m_sel + n - 1) % n;
      else if (act == 0) m_sel = (m_sel + 1) % n;
    end
  endtask
  task automatic step(input logic [3:0] b, input logic ft, input logic sd, input logic rs);
    {bus.btn_pause, bus.btn_enter, bus.btn_up, bus.btn_down} = b;
    bus.frame_tick = ft;
    bus.song_done = sd;
    reset = rs;
    @(posedge clk65);
    model(b, ft, sd, rs);
    #1;
    chk("state", bus.state, m_state);
    chk("menu_sel", bus.menu_sel, m_sel);
    chk("song_sel", bus.song_sel, m_song);
    chk("countdown", bus.countdown, m_cnt);
    chk("game_reset", bus.game_reset, m_grst);
    chk("game_start", bus.game_start, m_gstart);
    chk("pause", bus.pause, m_state != 2);
    chk("overlay_en", bus.overlay_en, m_state == 0 || m_state == 3);
  endtask
  task automatic press(input logic [3:0] b);
    step(b, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic ticks(input int n);
    repeat (n) step(4'b0000, 1'b1, 1'b0, 1'b0);
  endtask
  initial begin
    int exp_w[5];
    exp_w = '{1, 2, 3, 0, 1};
    {bus.btn_pause, bus.btn_enter, bus.btn_up, bus.btn_down} = 4'b0000;
    bus.frame_tick = 1'b0;
    bus.song_done = 1'b0;
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("rst_state", bus.state, 0);
    chk("rst_pause", bus.pause, 1);
    chk("rst_overlay", bus.overlay_en, 1);
    chk("rst_sel", bus.menu_sel, 0);
    chk("rst_cnt", bus.countdown, 0);
    for (int i = 0; i < 5; i++) begin
      press(4'b0001);
      chk("wrap_down", bus.menu_sel, exp_w[i]);
      chk("wrap_pause", bus.pause, 1);
    end
    press(4'b0010);
    chk("wrap_up", bus.menu_sel, 0);
    press(4'b0001);
    press(4'b0001);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("start_song", bus.song_sel, 2);
    chk("start_grst", bus.game_reset, 1);
    chk("start_cnt", bus.countdown, CF);
    chk("start_state", bus.state, 1);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("grst_once", bus.game_reset, 0);
    ticks(CF - 1);
    chk("go_start", bus.game_start, 1);
    chk("go_pause", bus.pause, 0);
    chk("go_cnt", bus.countdown, 0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("start_once", bus.game_start, 0);
    press(4'b1000);
    chk("pz_state", bus.state, 3);
    chk("pz_overlay", bus.overlay_en, 1);
    chk("pz_sel", bus.menu_sel, 0);
    press(4'b0001);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("restart_grst", bus.game_reset, 1);
    chk("restart_cnt", bus.countdown, CF);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    ticks(CF);
    chk("replay", bus.state, 2);
    step(4'b1101, 1'b0, 1'b0, 1'b0);
    chk("prio_state", bus.state, 3);
    chk("prio_sel", bus.menu_sel, 0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (1000) step(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("held_down", bus.menu_sel, 1);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    press(4'b1000);
    chk("resume", bus.state, 1);
    ticks(CF);
    step(4'b1000, 1'b0, 1'b1, 1'b0);
    chk("done_beats_pause", bus.state, 0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    press(4'b0100);
    press(4'b1000);
    press(4'b0001);
    press(4'b0001);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("quit_state", bus.state, 0);
    chk("quit_grst", bus.game_reset, 1);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    press(4'b0100);
    ticks(90);
    chk("mid_cnt", bus.countdown, 90);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("mid_state", bus.state, 0);
    chk("mid_cnt0", bus.countdown, 0);
    chk("mid_start", bus.game_start, 0);
    chk("mid_song", bus.song_sel, 0);
    rb = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) rb[i] = ~rb[i];
      step(rb, 1'($urandom_range(1)), $urandom_range(63) == 0, $urandom_range(499) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
